// File: rtl/mgmt_wb_router.sv
// Wishbone router from the management core master bus to NSLV slaves,
// with base/mask decode, per-slave enables and a per-transfer watchdog.
module mgmt_wb_router #(
    parameter int unsigned NSLV = 2,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h3000_0000, 32'h2600_0000},
    parameter logic [NSLV*AW-1:0] SLV_MASK = {32'hF000_0000, 32'hFF00_0000},
    parameter int unsigned TIMEOUT = 255,
    parameter logic [DW-1:0] ERR_DATA = 32'hBADC_0DE0
) (
    input  logic               core_clk,
    input  logic               core_rstn,
    input  logic               m_cyc_i,
    input  logic               m_stb_i,
    input  logic               m_we_i,
    input  logic [DW/8-1:0]    m_sel_i,
    input  logic [AW-1:0]      m_adr_i,
    input  logic [DW-1:0]      m_dat_i,
    output logic               m_ack_o,
    output logic               m_err_o,
    output logic [DW-1:0]      m_dat_o,
    output logic [NSLV-1:0]    s_cyc_o,
    output logic [NSLV-1:0]    s_stb_o,
    output logic               s_we_o,
    output logic [DW/8-1:0]    s_sel_o,
    output logic [AW-1:0]      s_adr_o,
    output logic [DW-1:0]      s_dat_o,
    input  logic [NSLV-1:0]    s_ack_i,
    input  logic [NSLV*DW-1:0] s_dat_i,
    input  logic [NSLV-1:0]    slv_iena_i,
    output logic               tmo_flag_o,
    input  logic               tmo_clr_i
);

    localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_e;

    state_e            state_q;
    logic [IW-1:0]     sel_q;
    logic [CW-1:0]     cnt_q;
    logic [NSLV-1:0]   cyc_q;
    logic              we_q;
    logic [DW/8-1:0]   be_q;
    logic [AW-1:0]     adr_q;
    logic [DW-1:0]     wdat_q;
    logic              ack_q;
    logic              err_q;
    logic [DW-1:0]     rdat_q;
    logic              tmo_q;

    logic              hit_d;
    logic [IW-1:0]     hit_idx_d;
    logic              ack_sel;
    logic [DW-1:0]     dat_sel;

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit_d = 1'b0;
        hit_idx_d = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (slv_iena_i[i] &&
                ((m_adr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
                hit_d = 1'b1;
                hit_idx_d = IW'(i);
            end
        end
    end

    assign ack_sel = s_ack_i[sel_q];
    assign dat_sel = s_dat_i[sel_q*DW +: DW];

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (tmo_clr_i) begin
                tmo_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        we_q   <= m_we_i;
                        be_q   <= m_sel_i;
                        adr_q  <= m_adr_i;
                        wdat_q <= m_dat_i;
                        if (hit_d) begin
                            sel_q   <= hit_idx_d;
                            cyc_q   <= NSLV'(1) << hit_idx_d;
                            cnt_q   <= '0;
                            state_q <= ACTIVE;
                        end else begin
                            rdat_q  <= ERR_DATA;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                ACTIVE: begin
                    if (!m_cyc_i) begin
                        cyc_q   <= '0;
                        state_q <= IDLE;
                    end else if (ack_sel) begin
                        cyc_q   <= '0;
                        rdat_q  <= dat_sel;
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q == TMO_LAST) begin
                        cyc_q   <= '0;
                        rdat_q  <= ERR_DATA;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        tmo_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_ack_o    = ack_q;
    assign m_err_o    = err_q;
    assign m_dat_o    = rdat_q;
    assign s_cyc_o    = cyc_q;
    assign s_stb_o    = cyc_q;
    assign s_we_o     = we_q;
    assign s_sel_o    = be_q;
    assign s_adr_o    = adr_q;
    assign s_dat_o    = wdat_q;
    assign tmo_flag_o = tmo_q;

endmodule

// File: tb/tb_mgmt_wb_router.sv
// Bench for mgmt_wb_router: directed steps, then random transfers
// against a transaction-level reference model.
module tb_mgmt_wb_router;

    localparam int TMO = 8;
    localparam logic [31:0] ERR = 32'hBADC_0DE0;

    logic        clk;
    logic        rstn;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat;
    logic        m_ack, m_err;
    logic [31:0] m_rdat;
    logic [1:0]  s_cyc, s_stb;
    logic        s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic [1:0]  s_ack;
    logic [63:0] s_rdat;
    logic [1:0]  iena;
    logic        tmo_flag, tmo_clr;

    int nerr = 0;
    int nchk = 0;
    logic flag_m = 1'b0;

    logic [31:0] base_m [2] = '{32'h2600_0000, 32'h3000_0000};
    logic [31:0] mask_m [2] = '{32'hFF00_0000, 32'hF000_0000};

    mgmt_wb_router #(.TIMEOUT(TMO)) dut (
        .core_clk(clk), .core_rstn(rstn),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wdat),
        .s_ack_i(s_ack), .s_dat_i(s_rdat), .slv_iena_i(iena),
        .tmo_flag_o(tmo_flag), .tmo_clr_i(tmo_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_tgt(input logic [31:0] a, input logic [1:0] en);
        for (int i = 0; i < 2; i++)
            if (en[i] && ((a & mask_m[i]) == base_m[i])) return i;
        return -1;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".ack"}, 64'(m_ack), 64'(0));
        chk({tag, ".err"}, 64'(m_err), 64'(0));
        chk({tag, ".stb"}, 64'(s_stb), 64'(0));
        chk({tag, ".cyc"}, 64'(s_cyc), 64'(0));
    endtask

    // One master transfer; the slave acks in its (ackd+1)th strobe cycle,
    // the master drops cyc in strobe cycle abrt (0 = never).
    task automatic xfer(input logic [31:0] adr, input logic we,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [1:0] en, input int ackd,
                        input int abrt, input string tag);
        int tgt, nstb, acks, ackcyc, bad1h, done_at;
        int e_nstb, e_ackcyc;
        logic [1:0] stbv;
        logic err, e_err, e_tmo;
        logic [31:0] rdat, e_dat;
        logic [31:0] sd [2];
        sd[0] = $urandom;
        sd[1] = $urandom;
        tgt = exp_tgt(adr, en);
        e_tmo = 1'b0;
        e_err = 1'b0;
        e_dat = '0;
        done_at = (ackd < TMO) ? ackd + 1 : TMO;
        if (tgt < 0) begin
            e_nstb = 0; e_ackcyc = 1; e_err = 1'b1; e_dat = ERR;
        end else if (abrt > 0 && abrt <= done_at) begin
            e_nstb = abrt; e_ackcyc = -1;
        end else if (ackd < TMO) begin
            e_nstb = ackd + 1; e_ackcyc = ackd + 2; e_dat = sd[tgt];
        end else begin
            e_nstb = TMO; e_ackcyc = TMO + 1;
            e_err = 1'b1; e_dat = ERR; e_tmo = 1'b1;
        end

        @(posedge clk); #1;
        iena = en;
        s_rdat = {sd[1], sd[0]};
        m_adr = adr; m_we = we; m_dat = dat; m_sel = sel;
        m_cyc = 1'b1; m_stb = 1'b1; s_ack = '0;
        nstb = 0; acks = 0; ackcyc = -1; bad1h = 0;
        stbv = '0; err = 1'b0; rdat = '0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (m_ack) begin
                acks++;
                if (ackcyc < 0) begin
                    ackcyc = c; err = m_err; rdat = m_rdat;
                end
                m_cyc = 1'b0; m_stb = 1'b0;
            end
            s_ack = 2'($urandom);
            if (tgt >= 0) s_ack[tgt] = 1'b0;
            if (|s_stb) begin
                nstb++;
                stbv |= s_stb;
                if (s_stb !== s_cyc) bad1h++;
                if (tgt >= 0 && nstb == ackd + 1) s_ack[tgt] = 1'b1;
                if (abrt > 0 && nstb == abrt) begin
                    m_cyc = 1'b0; m_stb = 1'b0;
                end
            end
        end
        s_ack = '0;
        m_cyc = 1'b0; m_stb = 1'b0;
        flag_m = flag_m | e_tmo;

        chk({tag, ".nstb"}, 64'(nstb), 64'(e_nstb));
        chk({tag, ".stbsel"}, 64'(stbv),
            64'((tgt < 0) ? 0 : (1 << tgt)));
        chk({tag, ".cyc_eq_stb"}, 64'(bad1h), 64'(0));
        chk({tag, ".ackcyc"}, 64'(ackcyc), 64'(e_ackcyc));
        chk({tag, ".nack"}, 64'(acks), 64'((e_ackcyc > 0) ? 1 : 0));
        if (e_ackcyc > 0) begin
            chk({tag, ".err"}, 64'(err), 64'(e_err));
            chk({tag, ".rdat"}, 64'(rdat), 64'(e_dat));
        end
        chk({tag, ".adr"}, 64'(s_adr), 64'(adr));
        chk({tag, ".wdat"}, 64'(s_wdat), 64'(dat));
        chk({tag, ".we"}, 64'(s_we), 64'(we));
        chk({tag, ".sel"}, 64'(s_sel), 64'(sel));
        chk({tag, ".tmo"}, 64'(tmo_flag), 64'(flag_m));
    endtask

    task automatic clr_flag(input string tag);
        @(posedge clk); #1;
        tmo_clr = 1'b1;
        @(posedge clk); #1;
        tmo_clr = 1'b0;
        flag_m = 1'b0;
        chk(tag, 64'(tmo_flag), 64'(0));
    endtask

    initial begin
        logic [31:0] a;
        int r;
        rstn = 1'b0; tmo_clr = 1'b0;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_sel = '0; m_adr = '0; m_dat = '0;
        s_ack = '0; s_rdat = '0; iena = 2'b11;
        #23;
        chk_idle_outputs("rst");
        chk("rst.dat", 64'(m_rdat), 64'(0));
        chk("rst.adr", 64'(s_adr), 64'(0));
        chk("rst.tmo", 64'(tmo_flag), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;

        xfer(32'h3000_0004, 1'b1, 32'hA5A5_5A5A, 4'hF, 2'b11, 0, 0, "wr1");
        xfer(32'h2600_0010, 1'b0, 32'h0, 4'hF, 2'b11, 3, 0, "rd0");
        xfer(32'h1000_0000, 1'b0, 32'h0, 4'h3, 2'b11, 0, 0, "unmap");
        xfer(32'h3000_0000, 1'b0, 32'h0, 4'hC, 2'b01, 0, 0, "dis1");
        xfer(32'h2600_0100, 1'b0, 32'h0, 4'hF, 2'b11, 99, 0, "tmo");
        xfer(32'h3000_0200, 1'b0, 32'h0, 4'hF, 2'b11, TMO - 1, 0, "ack8");
        clr_flag("clr");
        xfer(32'h2600_0300, 1'b1, 32'h5555_AAAA, 4'h1, 2'b11, 99, 2, "abort");
        xfer(32'h2600_0304, 1'b0, 32'h0, 4'hF, 2'b11, 1, 0, "postab");

        // Reset asserted in the middle of an ACTIVE transfer.
        @(posedge clk); #1;
        m_adr = 32'h3000_0040; m_cyc = 1'b1; m_stb = 1'b1; iena = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("mid.stb_pre", 64'(s_stb), 64'(2'b10));
        rstn = 1'b0;
        #1;
        chk_idle_outputs("mid");
        chk("mid.adr", 64'(s_adr), 64'(0));
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        flag_m = 1'b0;
        r = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (m_ack || |s_stb) r++;
        end
        chk("mid.quiet", 64'(r), 64'(0));
        xfer(32'h3000_0044, 1'b0, 32'h0, 4'hF, 2'b11, 2, 0, "fresh");

        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: a = {8'h26, a[23:0]};
                1: a = {4'h3, a[27:0]};
                2: a = {4'h1, a[27:0]};
                default: ;
            endcase
            xfer(a, 1'($urandom), $urandom, 4'($urandom),
                 ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom),
                 $urandom_range(0, 9),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0,
                 $sformatf("rnd%0d", n));
            if ($urandom_range(0, 7) == 0) clr_flag($sformatf("rclr%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
